// File: rtl/ddr3_port_arbiter.sv
// Shares one 64-bit Avalon-MM DDR3 port between the MPEG2 shim (m0, read/write)
// and the scanout reader (m1, reads only); a tag FIFO steers read returns back.
module ddr3_port_arbiter #(
    parameter int TAG_DEPTH = 8,
    parameter bit FAIR      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [28:0] m0_addr,
    input  logic [7:0]  m0_burstcnt,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [63:0] m0_writedata,
    input  logic [7:0]  m0_byteenable,
    output logic        m0_waitrequest,
    output logic        m0_readdatavalid,
    input  logic [28:0] m1_addr,
    input  logic [7:0]  m1_burstcnt,
    input  logic        m1_read,
    output logic        m1_waitrequest,
    output logic        m1_readdatavalid,
    output logic [63:0] rd_data,
    output logic [28:0] ddr3_addr,
    output logic [7:0]  ddr3_burstcnt,
    output logic        ddr3_read,
    output logic        ddr3_write,
    output logic [63:0] ddr3_writedata,
    output logic [7:0]  ddr3_byteenable,
    input  logic [63:0] ddr3_readdata,
    input  logic        ddr3_readdatavalid,
    input  logic        ddr3_waitrequest,
    output logic        err_orphan,
    output logic [1:0]  dbg_state
);
    // Handshake: a command beat transfers in any cycle where ddr3_read or
    // ddr3_write is high and ddr3_waitrequest is low; mX_waitrequest mirrors it.
    localparam int AW = $clog2(TAG_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        G0    = 2'd1,
        G1    = 2'd2,
        G0_WB = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        last_grant, last_grant_nxt;   // 0 = m0, 1 = m1
    logic [7:0]  wb_left, wb_left_nxt;

    logic        tag_id  [TAG_DEPTH];
    logic [7:0]  tag_len [TAG_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [8:0]  beat_cnt;
    logic        tag_full, tag_empty;
    logic        push, push_id, pop;
    logic [7:0]  push_len;
    logic        head_id;
    logic [7:0]  head_len;
    logic        m0_elig, m1_elig;

    assign tag_empty = (wr_ptr == rd_ptr);
    assign tag_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_id   = tag_id[rd_ptr[AW-1:0]];
    assign head_len  = tag_len[rd_ptr[AW-1:0]];
    assign pop       = ddr3_readdatavalid && !tag_empty && ((beat_cnt + 9'd1) == {1'b0, head_len});
    assign m0_elig   = m0_write || (m0_read && !tag_full);
    assign m1_elig   = m1_read && !tag_full;
    assign dbg_state = state;

    always_comb begin
        state_nxt       = state;
        last_grant_nxt  = last_grant;
        wb_left_nxt     = wb_left;
        m0_waitrequest  = 1'b1;
        m1_waitrequest  = 1'b1;
        ddr3_addr       = '0;
        ddr3_burstcnt   = '0;
        ddr3_read       = 1'b0;
        ddr3_write      = 1'b0;
        ddr3_writedata  = '0;
        ddr3_byteenable = '0;
        push            = 1'b0;
        push_id         = 1'b0;
        push_len        = m0_burstcnt;
        case (state)
            IDLE: begin
                if (m0_elig && m1_elig) begin
                    if (FAIR) state_nxt = last_grant ? G0 : G1;
                    else      state_nxt = G1;
                end else if (m0_elig) begin
                    state_nxt = G0;
                end else if (m1_elig) begin
                    state_nxt = G1;
                end
            end
            G0: begin
                ddr3_addr       = m0_addr;
                ddr3_burstcnt   = m0_burstcnt;
                ddr3_writedata  = m0_writedata;
                ddr3_byteenable = m0_byteenable;
                ddr3_write      = m0_write;
                ddr3_read       = m0_read && !m0_write && !tag_full;
                if (m0_write) begin
                    m0_waitrequest = ddr3_waitrequest;
                    if (!ddr3_waitrequest) begin
                        if (m0_burstcnt == 8'd1) begin
                            state_nxt      = IDLE;
                            last_grant_nxt = 1'b0;
                        end else begin
                            state_nxt   = G0_WB;
                            wb_left_nxt = m0_burstcnt - 8'd1;
                        end
                    end
                end else if (ddr3_read) begin
                    m0_waitrequest = ddr3_waitrequest;
                    if (!ddr3_waitrequest) begin
                        push           = 1'b1;
                        push_id        = 1'b0;
                        push_len       = m0_burstcnt;
                        state_nxt      = IDLE;
                        last_grant_nxt = 1'b0;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            G1: begin
                ddr3_addr     = m1_addr;
                ddr3_burstcnt = m1_burstcnt;
                ddr3_read     = m1_read && !tag_full;
                if (ddr3_read) begin
                    m1_waitrequest = ddr3_waitrequest;
                    if (!ddr3_waitrequest) begin
                        push           = 1'b1;
                        push_id        = 1'b1;
                        push_len       = m1_burstcnt;
                        state_nxt      = IDLE;
                        last_grant_nxt = 1'b1;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            G0_WB: begin
                // m0 owns the port until every beat of the write burst is taken
                ddr3_addr       = m0_addr;
                ddr3_burstcnt   = m0_burstcnt;
                ddr3_writedata  = m0_writedata;
                ddr3_byteenable = m0_byteenable;
                ddr3_write      = m0_write;
                m0_waitrequest  = ddr3_waitrequest;
                if (m0_write && !ddr3_waitrequest) begin
                    wb_left_nxt = wb_left - 8'd1;
                    if (wb_left == 8'd1) begin
                        state_nxt      = IDLE;
                        last_grant_nxt = 1'b0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wb_left    <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            wb_left    <= wb_left_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_id[wr_ptr[AW-1:0]]  <= push_id;
            tag_len[wr_ptr[AW-1:0]] <= push_len;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            beat_cnt         <= '0;
            rd_data          <= '0;
            m0_readdatavalid <= 1'b0;
            m1_readdatavalid <= 1'b0;
            err_orphan       <= 1'b0;
        end else begin
            rd_data          <= ddr3_readdata;
            m0_readdatavalid <= 1'b0;
            m1_readdatavalid <= 1'b0;
            if (ddr3_readdatavalid) begin
                if (tag_empty) begin
                    err_orphan <= 1'b1;
                end else begin
                    m0_readdatavalid <= !head_id;
                    m1_readdatavalid <= head_id;
                    beat_cnt         <= pop ? 9'd0 : beat_cnt + 9'd1;
                end
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Directed bench for ddr3_port_arbiter: a round-robin instance (dut) and a
// fixed-priority instance (dut_f) share every input.
module tb_ddr3_port_arbiter;

    logic        clk;
    logic        rst;
    logic [28:0] m0_addr;
    logic [7:0]  m0_burstcnt;
    logic        m0_read;
    logic        m0_write;
    logic [63:0] m0_writedata;
    logic [7:0]  m0_byteenable;
    logic [28:0] m1_addr;
    logic [7:0]  m1_burstcnt;
    logic        m1_read;
    logic [63:0] ddr3_readdata;
    logic        ddr3_readdatavalid;
    logic        ddr3_waitrequest;

    logic        m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
    logic [63:0] rd_data;
    logic [28:0] ddr3_addr;
    logic [7:0]  ddr3_burstcnt;
    logic        ddr3_read, ddr3_write;
    logic [63:0] ddr3_writedata;
    logic [7:0]  ddr3_byteenable;
    logic        err_orphan;
    logic [1:0]  dbg_state;

    logic        f_m0_waitrequest, f_m0_readdatavalid, f_m1_waitrequest, f_m1_readdatavalid;
    logic [63:0] f_rd_data;
    logic [28:0] f_ddr3_addr;
    logic [7:0]  f_ddr3_burstcnt;
    logic        f_ddr3_read, f_ddr3_write;
    logic [63:0] f_ddr3_writedata;
    logic [7:0]  f_ddr3_byteenable;
    logic        f_err_orphan;
    logic [1:0]  f_dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    ddr3_port_arbiter #(.TAG_DEPTH(8), .FAIR(1'b1)) dut (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m0_burstcnt(m0_burstcnt), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdatavalid(m0_readdatavalid),
        .m1_addr(m1_addr), .m1_burstcnt(m1_burstcnt), .m1_read(m1_read),
        .m1_waitrequest(m1_waitrequest), .m1_readdatavalid(m1_readdatavalid),
        .rd_data(rd_data),
        .ddr3_addr(ddr3_addr), .ddr3_burstcnt(ddr3_burstcnt), .ddr3_read(ddr3_read),
        .ddr3_write(ddr3_write), .ddr3_writedata(ddr3_writedata),
        .ddr3_byteenable(ddr3_byteenable), .ddr3_readdata(ddr3_readdata),
        .ddr3_readdatavalid(ddr3_readdatavalid), .ddr3_waitrequest(ddr3_waitrequest),
        .err_orphan(err_orphan), .dbg_state(dbg_state)
    );

    ddr3_port_arbiter #(.TAG_DEPTH(8), .FAIR(1'b0)) dut_f (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m0_burstcnt(m0_burstcnt), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(f_m0_waitrequest), .m0_readdatavalid(f_m0_readdatavalid),
        .m1_addr(m1_addr), .m1_burstcnt(m1_burstcnt), .m1_read(m1_read),
        .m1_waitrequest(f_m1_waitrequest), .m1_readdatavalid(f_m1_readdatavalid),
        .rd_data(f_rd_data),
        .ddr3_addr(f_ddr3_addr), .ddr3_burstcnt(f_ddr3_burstcnt), .ddr3_read(f_ddr3_read),
        .ddr3_write(f_ddr3_write), .ddr3_writedata(f_ddr3_writedata),
        .ddr3_byteenable(f_ddr3_byteenable), .ddr3_readdata(ddr3_readdata),
        .ddr3_readdatavalid(ddr3_readdatavalid), .ddr3_waitrequest(ddr3_waitrequest),
        .err_orphan(f_err_orphan), .dbg_state(f_dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (!((m0_read || m0_write) && m0_burstcnt == 8'd0)) else $error("m0 burstcnt of zero");
            assert (!(m1_read && m1_burstcnt == 8'd0)) else $error("m1 burstcnt of zero");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_addr = '0; m0_burstcnt = 8'd1; m0_read = 1'b0; m0_write = 1'b0;
        m0_writedata = '0; m0_byteenable = 8'hFF;
        m1_addr = '0; m1_burstcnt = 8'd1; m1_read = 1'b0;
        ddr3_readdata = '0; ddr3_readdatavalid = 1'b0; ddr3_waitrequest = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        #1;
        check("rst_read",  {63'd0, ddr3_read}, 64'd0);
        check("rst_write", {63'd0, ddr3_write}, 64'd0);
        check("rst_m0_wr", {63'd0, m0_waitrequest}, 64'd1);
        check("rst_m1_wr", {63'd0, m1_waitrequest}, 64'd1);
        check("rst_rdv",   {62'd0, m0_readdatavalid, m1_readdatavalid}, 64'd0);
        check("rst_err",   {63'd0, err_orphan}, 64'd0);
        check("rst_f_all", {58'd0, f_ddr3_read, f_ddr3_write, f_m0_readdatavalid,
                            f_m1_readdatavalid, f_err_orphan, f_dbg_state == 2'd0}, 64'd1);
        check("rst_f_rd_data", f_rd_data, 64'd0);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        bit found;
        rst = 1'b1;
        idle_inputs();

        // 1: single m0 write
        do_reset();
        m0_write = 1'b1; m0_addr = 29'h1800000; m0_writedata = 64'hDEADBEEFCAFEBABE;
        m0_burstcnt = 8'd1;
        #1;
        check("t1_idle_write", {63'd0, ddr3_write}, 64'd0);
        check("t1_idle_m0_wr", {63'd0, m0_waitrequest}, 64'd1);
        cyc();
        #1;
        check("t1_write", {63'd0, ddr3_write}, 64'd1);
        check("t1_addr", {35'd0, ddr3_addr}, 64'h1800000);
        check("t1_data", ddr3_writedata, 64'hDEADBEEFCAFEBABE);
        check("t1_bcnt", {56'd0, ddr3_burstcnt}, 64'd1);
        check("t1_m0_wr", {63'd0, m0_waitrequest}, 64'd0);
        cyc();
        m0_write = 1'b0;
        #1;
        check("t1_back_idle", {62'd0, dbg_state}, 64'd0);
        check("t1_m0_wr_after", {63'd0, m0_waitrequest}, 64'd1);
        check("t1_write_after", {63'd0, ddr3_write}, 64'd0);

        // 2: simultaneous reads, m0 first, then returns steered by tag
        do_reset();
        m0_read = 1'b1; m0_burstcnt = 8'd1; m0_addr = 29'h100;
        m1_read = 1'b1; m1_burstcnt = 8'd4; m1_addr = 29'h200;
        cyc();
        #1;
        check("t2_g0_read", {63'd0, ddr3_read}, 64'd1);
        check("t2_g0_addr", {35'd0, ddr3_addr}, 64'h100);
        check("t2_g0_wr", {62'd0, m0_waitrequest, m1_waitrequest}, 64'd1);
        cyc();
        m0_read = 1'b0;
        #1;
        check("t2_idle_read", {63'd0, ddr3_read}, 64'd0);
        cyc();
        #1;
        check("t2_g1_read", {63'd0, ddr3_read}, 64'd1);
        check("t2_g1_addr", {35'd0, ddr3_addr}, 64'h200);
        check("t2_g1_bcnt", {56'd0, ddr3_burstcnt}, 64'd4);
        check("t2_g1_wr", {62'd0, m0_waitrequest, m1_waitrequest}, 64'd2);
        cyc();
        m1_read = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ddr3_readdatavalid = 1'b1;
            ddr3_readdata = 64'hA + 64'(i);
            exp_q.push_back(64'hA + 64'(i));
            if (i == 0) begin
                #1;
                check("t2_latency", {62'd0, m0_readdatavalid, m1_readdatavalid}, 64'd0);
            end
            cyc();
            check($sformatf("t2_rdv_%0d", i), {62'd0, m0_readdatavalid, m1_readdatavalid},
                  (i == 0) ? 64'd2 : 64'd1);
            check($sformatf("t2_data_%0d", i), rd_data, exp_q.pop_front());
        end
        ddr3_readdatavalid = 1'b0;
        cyc();
        check("t2_rdv_done", {61'd0, m0_readdatavalid, m1_readdatavalid, err_orphan}, 64'd0);

        // 3: m0 write burst of 4 with a stall on beat 2, m1 waiting
        do_reset();
        m0_write = 1'b1; m0_burstcnt = 8'd4; m0_addr = 29'h40; m0_writedata = 64'hD0;
        m1_read = 1'b1; m1_burstcnt = 8'd1; m1_addr = 29'h300;
        cyc();
        #1;
        check("t3_b0_data", ddr3_writedata, 64'hD0);
        check("t3_b0_bcnt", {56'd0, ddr3_burstcnt}, 64'd4);
        check("t3_b0_wr", {62'd0, m0_waitrequest, m1_waitrequest}, 64'd1);
        cyc();
        m0_writedata = 64'hD1; ddr3_waitrequest = 1'b1;
        #1;
        check("t3_wb_state", {62'd0, dbg_state}, 64'd3);
        check("t3_stall_wr", {62'd0, m0_waitrequest, m1_waitrequest}, 64'd3);
        cyc();
        ddr3_waitrequest = 1'b0;
        #1;
        check("t3_b1_data", ddr3_writedata, 64'hD1);
        check("t3_b1_wr", {62'd0, m0_waitrequest, m1_waitrequest}, 64'd1);
        cyc();
        m0_writedata = 64'hD2;
        #1;
        check("t3_b2_data", {ddr3_writedata[62:0], ddr3_write}, {63'hD2, 1'b1});
        cyc();
        m0_writedata = 64'hD3;
        #1;
        check("t3_b3_data", {ddr3_writedata[62:0], ddr3_write}, {63'hD3, 1'b1});
        check("t3_b3_m1_wr", {63'd0, m1_waitrequest}, 64'd1);
        cyc();
        m0_write = 1'b0;
        #1;
        check("t3_after_idle", {61'd0, dbg_state, ddr3_write}, 64'd0);
        cyc();
        #1;
        check("t3_m1_grant", {62'd0, ddr3_read, m1_waitrequest}, 64'd2);
        check("t3_m1_addr", {35'd0, ddr3_addr}, 64'h300);
        cyc();
        m1_read = 1'b0;

        // 4: tag FIFO full holds off the ninth read
        do_reset();
        m1_read = 1'b1; m1_burstcnt = 8'd2; m1_addr = 29'd0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            #1;
            check($sformatf("t4_issue_%0d", k), {34'd0, ddr3_addr, ddr3_read}, {34'd0, 29'(k), 1'b1});
            cyc();
            m1_addr = 29'(k + 1);
        end
        for (int k = 0; k < 3; k++) begin
            cyc();
            #1;
            check($sformatf("t4_held_%0d", k), {62'd0, ddr3_read, m1_waitrequest}, 64'd1);
        end
        ddr3_readdatavalid = 1'b1; ddr3_readdata = 64'h11;
        cyc();
        check("t4_ret1", {62'd0, m0_readdatavalid, m1_readdatavalid}, 64'd1);
        ddr3_readdata = 64'h12;
        cyc();
        ddr3_readdatavalid = 1'b0;
        check("t4_ret2", {62'd0, m0_readdatavalid, m1_readdatavalid}, 64'd1);
        check("t4_ret2_data", rd_data, 64'h12);
        found = 1'b0;
        n = 0;
        for (int w = 1; w <= 5 && !found; w++) begin
            cyc();
            #1;
            n = w;
            if (ddr3_read && !m1_waitrequest) found = 1'b1;
        end
        check("t4_release_found", {63'd0, found}, 64'd1);
        check("t4_release_within_2", {63'd0, n <= 2}, 64'd1);
        check("t4_release_addr", {35'd0, ddr3_addr}, 64'd8);
        cyc();
        m1_read = 1'b0;

        // 5: fixed priority instance, both requesting continuously
        do_reset();
        m0_write = 1'b1; m0_burstcnt = 8'd1; m0_addr = 29'h500; m0_writedata = 64'h55;
        m0_byteenable = 8'h0F;
        m1_read = 1'b1; m1_burstcnt = 8'd1; m1_addr = 29'h600;
        for (int k = 0; k < 3; k++) begin
            cyc();
            #1;
            check($sformatf("t5_m1_wins_%0d", k),
                  {60'd0, f_ddr3_read, f_ddr3_write, f_m0_waitrequest, f_m1_waitrequest}, 64'b1010);
            check($sformatf("t5_m1_cmd_%0d", k), {27'd0, f_ddr3_addr, f_ddr3_burstcnt},
                  {27'd0, 29'h600, 8'd1});
            cyc();
        end
        m1_read = 1'b0;
        cyc();
        #1;
        check("t5_m0_served", {60'd0, f_ddr3_read, f_ddr3_write, f_m0_waitrequest, f_m1_waitrequest},
              64'b0101);
        check("t5_m0_data", f_ddr3_writedata, 64'h55);
        check("t5_m0_be", {56'd0, f_ddr3_byteenable}, 64'h0F);
        check("t5_f_state", {62'd0, f_dbg_state}, 64'd1);
        cyc();
        m0_write = 1'b0;

        // 6: orphan beat, then reset in the middle of a write burst
        do_reset();
        ddr3_readdatavalid = 1'b1; ddr3_readdata = 64'h77;
        #1;
        check("t6_err_before", {63'd0, err_orphan}, 64'd0);
        cyc();
        ddr3_readdatavalid = 1'b0;
        check("t6_err_set", {61'd0, err_orphan, m0_readdatavalid, m1_readdatavalid}, 64'b100);
        cyc();
        cyc();
        check("t6_err_sticky", {61'd0, err_orphan, m0_readdatavalid, m1_readdatavalid}, 64'b100);
        m0_write = 1'b1; m0_burstcnt = 8'd4; m0_addr = 29'h80; m0_writedata = 64'h99;
        cyc();
        cyc();
        #1;
        check("t6_mid_burst", {61'd0, dbg_state, ddr3_write}, 64'b111);
        rst = 1'b1;
        cyc();
        #1;
        check("t6_rst_write", {63'd0, ddr3_write}, 64'd0);
        check("t6_rst_state", {62'd0, dbg_state}, 64'd0);
        check("t6_rst_err", {62'd0, err_orphan, m0_waitrequest}, 64'd1);
        rst = 1'b0;
        m0_write = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
